cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache and the data cache of the pipelined RV32I core.
- Accepts cache-line miss/writeback requests from both caches and serializes them onto one pmem port with an FSM.
- Returns read data and a one-cycle response pulse to the requester that was granted.
- Sits between the two L1 caches and the memory model / L2.

Parameters:
- ADDR_WIDTH, 32, width of the line address on all ports.
- LINE_WIDTH, 256, cache line width in bits on all data ports.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_pmem_read  in  1  icache line-read request.
- i_pmem_address  in  ADDR_WIDTH  icache line address.
- i_pmem_rdata  out  LINE_WIDTH  line returned to icache.
- i_pmem_resp  out  1  icache completion pulse.
- d_pmem_read  in  1  dcache line-read request.
- d_pmem_write  in  1  dcache line-writeback request.
- d_pmem_address  in  ADDR_WIDTH  dcache line address.
- d_pmem_wdata  in  LINE_WIDTH  dcache writeback line.
- d_pmem_rdata  out  LINE_WIDTH  line returned to dcache.
- d_pmem_resp  out  1  dcache completion pulse.
- pmem_read  out  1  memory read command.
- pmem_write  out  1  memory write command.
- pmem_address  out  ADDR_WIDTH  memory line address.
- pmem_wdata  out  LINE_WIDTH  memory write line.
- pmem_rdata  in  LINE_WIDTH  memory read line.
- pmem_resp  in  1  memory completion pulse.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- FSM states: IDLE, SERVE_I, SERVE_D, RELEASE.
- Reset:
  - State goes to IDLE.
  - pmem_read, pmem_write, pmem_address and pmem_wdata are cleared to 0.
  - Both requester resp outputs are 0.
  - The last_grant register is set to ICACHE.
- IDLE:
  - If any request is high at edge N, the arbiter selects a winner.
  - At that same edge it latches the winner's address into pmem_address and, for a dcache write, d_pmem_wdata into pmem_wdata.
  - pmem_read or pmem_write is asserted starting at cycle N+1 and is a registered output.
- Tie rule (both caches requesting): the dcache wins.
- dcache request rules:
  - d_pmem_write takes precedence over d_pmem_read.
  - Both high at once is illegal, but the arbiter still issues a write.
- SERVE_I / SERVE_D:
  - The pmem command and latched address/wdata stay stable until pmem_resp.
  - Requester inputs are ignored after grant. A requester dropping its request mid-transaction does not abort it.
- Completion cycle M (pmem_resp=1):
  - The granted requester's resp is driven combinationally to 1 in cycle M.
  - Its rdata equals pmem_rdata in cycle M; this applies to reads only, and a write resp has don't-care rdata.
  - At edge M, pmem_read and pmem_write clear, last_grant updates, and state goes to RELEASE.
- RELEASE: lasts exactly one cycle, with no grant and no command, so the requester can deassert. Then state returns to IDLE.
- Timing: the earliest next pmem command is cycle M+3.
- Non-granted outputs: the resp of the requester not granted is always 0.
- rdata outputs: may mirror pmem_rdata at all times; only valid when the matching resp is 1.
- pmem_resp outside SERVE_I/SERVE_D is ignored, with no resp pulse.
- rst asserted mid-transaction:
  - The FSM returns to IDLE, commands drop the next cycle, and the transaction is abandoned.
  - Memory must also be reset.
- Starvation: without the optional feature, a continuously requesting dcache can starve the icache. This is accepted, because the pipeline stalls on a dcache miss.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- When defined: ties in IDLE go to the cache not equal to last_grant.
  - After reset (last_grant=ICACHE), the dcache wins the first tie.
  - Non-tie grants behave exactly as in the base design.
  - last_grant is updated on every completion.
- When undefined: the dcache always wins ties, and the last_grant register is omitted.

Test Plan:
- Icache-only read: i_pmem_read=1, addr 0x0000_1000 at cycle 0 → pmem_read=1 and pmem_address=0x0000_1000 from cycle 1. Memory responds at cycle 5 with rdata=0xA5…A5 → i_pmem_resp=1 only in cycle 5 with i_pmem_rdata=0xA5…A5, d_pmem_resp=0, and pmem_read=0 from cycle 6.
- Dcache writeback: d_pmem_write=1, addr 0x0000_2040, wdata=0x1234…: pmem_write=1 and pmem_wdata matches until pmem_resp; d_pmem_resp pulses one cycle; pmem_read stays 0 throughout.
- Tie, base build: i_pmem_read and d_pmem_read both high at cycle 0 → dcache served first. After its resp and the RELEASE cycle, the icache is granted with pmem_read re-asserted at M+3.
- Tie, ARB_ROUND_ROBIN_EN build:
  - Three back-to-back ties → grant order D, I, D.
  - Base build under the same stimulus → D, D, D.
- Spurious and abort: pmem_resp=1 in IDLE → no resp pulse, state unchanged. rst=1 during SERVE_D → pmem_write=0 the next cycle, state IDLE, last_grant=ICACHE.
- Request drop: the icache deasserts i_pmem_read after grant → the command is held until pmem_resp, and i_pmem_resp still pulses once.

Source files
------------

// File: rtl/cache_arbiter.sv
// Arbitrates one physical-memory port between the icache and dcache line-miss/writeback traffic.
// Optional round-robin tie breaking is enabled with `define ARB_ROUND_ROBIN_EN.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t                state, state_next;
  logic                  read_next, write_next;
  logic [ADDR_WIDTH-1:0] address_next;
  logic [LINE_WIDTH-1:0] wdata_next;
  logic                  i_req, d_req, pick_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
  typedef enum logic {ICACHE, DCACHE} grant_t;
  grant_t last_grant, last_grant_next;

  // On a tie the cache that was not served last wins.
  assign pick_d = d_req & (~i_req | (last_grant == ICACHE));
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_next   = state;
    read_next    = pmem_read;
    write_next   = pmem_write;
    address_next = pmem_address;
    wdata_next   = pmem_wdata;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_next = last_grant;
`endif
    case (state)
      IDLE: begin
        if (pick_d) begin
          state_next   = SERVE_D;
          address_next = d_pmem_address;
          // A write wins even if the illegal read+write combination shows up.
          if (d_pmem_write) begin
            write_next = 1'b1;
            wdata_next = d_pmem_wdata;
          end else begin
            read_next = 1'b1;
          end
        end else if (i_req) begin
          state_next   = SERVE_I;
          read_next    = 1'b1;
          address_next = i_pmem_address;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_next = RELEASE;
          read_next  = 1'b0;
          write_next = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_next = (state == SERVE_D) ? DCACHE : ICACHE;
`endif
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant   <= ICACHE;
`endif
    end else begin
      state        <= state_next;
      pmem_read    <= read_next;
      pmem_write   <= write_next;
      pmem_address <= address_next;
      pmem_wdata   <= wdata_next;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant   <= last_grant_next;
`endif
    end
  end

  // Memory completion is forwarded straight through to whoever holds the grant.
  assign i_pmem_resp  = (state == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed cache requests, a latency-driven memory model,
// and one monitor that checks every pmem command and every requester response.
module tb_cache_arbiter;

  localparam int AW      = 32;
  localparam int LW      = 256;
  localparam int MEM_LAT = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read, d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          force_resp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            gap;
  } cmd_t;

  typedef struct {
    bit            is_d;
    bit            is_read;
    logic [LW-1:0] rdata;
  } resp_t;

  cmd_t  cmd_q[$];
  resp_t resp_q[$];

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    if (a == 32'h0000_1000) return {32{8'hA5}};
    return {8{a}};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input bit rd, input bit wr, input logic [AW-1:0] a,
                          input logic [LW-1:0] wd, input int gap);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = a; c.wdata = wd; c.gap = gap;
    cmd_q.push_back(c);
  endtask

  task automatic push_resp(input bit is_d, input bit is_read, input logic [AW-1:0] a);
    resp_t r;
    r.is_d = is_d; r.is_read = is_read; r.rdata = line_of(a);
    resp_q.push_back(r);
  endtask

  task automatic release_req(input bit is_d);
    if (is_d) begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end else begin
      i_pmem_read = 1'b0;
    end
  endtask

  // Raise a request, optionally drop it early, and hold until the cache sees its resp.
  task automatic drive(input bit is_d, input bit wr, input logic [AW-1:0] a,
                       input logic [LW-1:0] wd, input int drop_after);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    if (is_d) begin
      d_pmem_address = a;
      d_pmem_wdata   = wd;
      if (wr) d_pmem_write = 1'b1;
      else    d_pmem_read  = 1'b1;
    end else begin
      i_pmem_address = a;
      i_pmem_read    = 1'b1;
    end
    for (int n = 1; n <= 200 && !seen; n++) begin
      @(negedge clk);
      if (is_d ? d_pmem_resp : i_pmem_resp) seen = 1'b1;
      else if (n == drop_after) begin
        @(posedge clk); #1;
        release_req(is_d);
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL drive_timeout: no resp for addr %0h", a);
    end
    @(posedge clk); #1;
    release_req(is_d);
  endtask

  // Memory model: responds MEM_LAT cycles into a command; forgets everything on reset.
  initial begin : memory
    int mcnt;
    logic auto_resp;
    mcnt = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      auto_resp = 1'b0;
      if (rst || !(pmem_read || pmem_write)) mcnt = 0;
      else begin
        mcnt++;
        if (mcnt == MEM_LAT) auto_resp = 1'b1;
      end
      pmem_resp  = auto_resp | force_resp;
      pmem_rdata = line_of(pmem_address);
    end
  end

  // Monitor: pops the expected command on each new pmem command and the expected response on each resp.
  initial begin : monitor
    bit    cmd_active, cmd_unstable, post_resp;
    int    last_resp_cyc;
    cmd_t  ec, held;
    resp_t er;
    cmd_active = 0; cmd_unstable = 0; post_resp = 0; last_resp_cyc = 0;
    forever begin
      @(negedge clk);
      if (post_resp) begin
        post_resp = 0;
        chk("cmd_clear_after_resp", {pmem_read, pmem_write}, 2'b00);
      end
      if (i_pmem_resp || d_pmem_resp) begin
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: i=%0b d=%0b with nothing outstanding", i_pmem_resp, d_pmem_resp);
        end else begin
          er = resp_q.pop_front();
          chk("resp_target", {i_pmem_resp, d_pmem_resp}, {~er.is_d, er.is_d});
          if (er.is_read) chk("resp_rdata", er.is_d ? d_pmem_rdata : i_pmem_rdata, er.rdata);
        end
        last_resp_cyc = cyc;
        post_resp = 1;
      end
      if (!cmd_active && (pmem_read || pmem_write)) begin
        cmd_active   = 1;
        cmd_unstable = 0;
        held.rd = pmem_read; held.wr = pmem_write; held.addr = pmem_address; held.wdata = pmem_wdata;
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd: rd=%0b wr=%0b addr=%0h", pmem_read, pmem_write, pmem_address);
        end else begin
          ec = cmd_q.pop_front();
          chk("cmd_kind", {pmem_read, pmem_write}, {ec.rd, ec.wr});
          chk("cmd_addr", pmem_address, ec.addr);
          if (ec.wr) chk("cmd_wdata", pmem_wdata, ec.wdata);
          if (ec.gap >= 0) chk("cmd_gap", cyc - last_resp_cyc, ec.gap);
        end
      end else if (cmd_active) begin
        if (pmem_read || pmem_write) begin
          if (pmem_read != held.rd || pmem_write != held.wr || pmem_address != held.addr ||
              pmem_wdata != held.wdata) cmd_unstable = 1;
        end else begin
          cmd_active = 0;
          chk("cmd_stable", cmd_unstable, 1'b0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [LW-1:0] wd1, wd2;
    int n, limit;
    wd1 = {8{32'h1234_5678}};
    wd2 = {8{32'hDEAD_BEEF}};
    rst = 1'b1; force_resp = 1'b0;
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_address", pmem_address, '0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(posedge clk); #1; rst = 1'b0;

    // Icache read with the A5 line, then a dcache writeback.
    push_cmd(1, 0, 32'h0000_1000, '0, -1); push_resp(0, 1, 32'h0000_1000);
    drive(0, 0, 32'h0000_1000, '0, 0);
    push_cmd(0, 1, 32'h0000_2040, wd1, -1); push_resp(1, 0, 32'h0000_2040);
    drive(1, 1, 32'h0000_2040, wd1, 0);

    // Icache drops its request right after grant.
    push_cmd(1, 0, 32'h0000_1100, '0, -1); push_resp(0, 1, 32'h0000_1100);
    drive(0, 0, 32'h0000_1100, '0, 2);

    // Single tie: dcache first, icache re-commanded three cycles after the dcache resp.
    push_cmd(1, 0, 32'h0000_4000, '0, -1); push_resp(1, 1, 32'h0000_4000);
    push_cmd(1, 0, 32'h0000_3000, '0, 3);  push_resp(0, 1, 32'h0000_3000);
    fork
      drive(1, 0, 32'h0000_4000, '0, 0);
      drive(0, 0, 32'h0000_3000, '0, 0);
    join

    // Both caches request continuously; dcache drops after the third grant.
`ifdef ARB_ROUND_ROBIN_EN
    push_cmd(1, 0, 32'h0000_4000, '0, -1); push_resp(1, 1, 32'h0000_4000);
    push_cmd(1, 0, 32'h0000_3000, '0, 3);  push_resp(0, 1, 32'h0000_3000);
    push_cmd(1, 0, 32'h0000_4000, '0, 3);  push_resp(1, 1, 32'h0000_4000);
`else
    push_cmd(1, 0, 32'h0000_4000, '0, -1); push_resp(1, 1, 32'h0000_4000);
    push_cmd(1, 0, 32'h0000_4000, '0, 3);  push_resp(1, 1, 32'h0000_4000);
    push_cmd(1, 0, 32'h0000_4000, '0, 3);  push_resp(1, 1, 32'h0000_4000);
`endif
    push_cmd(1, 0, 32'h0000_3000, '0, 3);  push_resp(0, 1, 32'h0000_3000);
    @(posedge clk); #1;
    i_pmem_address = 32'h0000_3000; i_pmem_read = 1'b1;
    d_pmem_address = 32'h0000_4000; d_pmem_read = 1'b1;
    n = 0;
    for (limit = 4; limit > 0; limit--) begin
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (i_pmem_resp || d_pmem_resp) break;
      end
      if (!(i_pmem_resp || d_pmem_resp)) begin
        checks++; errors++;
        $display("FAIL tie_stream_timeout: got %0d of 4 resps", n);
        break;
      end
      n++;
      @(posedge clk); #1;
      if (n == 3) d_pmem_read = 1'b0;
      if (n == 4) i_pmem_read = 1'b0;
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;

    // Spurious memory resp while idle must not reach either cache.
    repeat (2) @(posedge clk); #1;
    force_resp = 1'b1;
    @(negedge clk);
    chk("spurious_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(posedge clk); #1; force_resp = 1'b0;

    // Dcache read leaves it as last served; then abort a writeback with reset.
    push_cmd(1, 0, 32'h0000_6000, '0, -1); push_resp(1, 1, 32'h0000_6000);
    drive(1, 0, 32'h0000_6000, '0, 0);
    push_cmd(0, 1, 32'h0000_5000, wd2, -1);
    @(posedge clk); #1;
    d_pmem_address = 32'h0000_5000; d_pmem_wdata = wd2; d_pmem_write = 1'b1;
    for (int t = 0; t < 20 && !pmem_write; t++) @(negedge clk);
    chk("abort_cmd_seen", pmem_write, 1'b1);
    @(posedge clk); #1; rst = 1'b1; d_pmem_write = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("abort_write_dropped", pmem_write, 1'b0);
    chk("abort_addr_cleared", pmem_address, '0);

    // Tie after reset: dcache must win again.
    push_cmd(1, 0, 32'h0000_4000, '0, -1); push_resp(1, 1, 32'h0000_4000);
    push_cmd(1, 0, 32'h0000_3000, '0, 3);  push_resp(0, 1, 32'h0000_3000);
    fork
      drive(1, 0, 32'h0000_4000, '0, 0);
      drive(0, 0, 32'h0000_3000, '0, 0);
    join

    repeat (5) @(posedge clk);
    chk("cmd_queue_drained", cmd_q.size(), 0);
    chk("resp_queue_drained", resp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
